// File: rtl/sau_pkg.sv
// ---------------------------------------------------------------------------
// sau_pkg
// Shared definitions for the shift-add unit (sau_pipe):
//   - default configuration constants
//   - sau_out_w(): result width, one bit wider than the largest magnitude so
//     that negating the most negative sample times NUM_MULT stays exact
//   - sau_tz() / sau_csd_digit(): elaboration-time helpers used to build the
//     constant multiples from shifts and adds
//   - sau_s1_t: stage-1 record for the default configuration
// ---------------------------------------------------------------------------
package sau_pkg;

  localparam int SAU_WIDTH     = 20;
  localparam int SAU_MULT_BITS = 4;
  localparam int SAU_TAG_W     = 8;
  localparam int NUM_MULT      = 2 ** SAU_MULT_BITS;

  function automatic int sau_out_w(input int width, input int mult_bits);
    return width + mult_bits + 1;
  endfunction

  // Number of trailing zero bits of m: (k+1) = 2^tz * odd.
  function automatic int sau_tz(input int m);
    int s;
    bit found;
    s     = 0;
    found = 1'b0;
    for (int i = 0; i < 31; i++) begin
      if (!found && m[i]) begin
        s     = i;
        found = 1'b1;
      end
    end
    return s;
  endfunction

  // Canonical signed-digit recoding of constant c; returns the digit
  // (-1, 0, +1) at bit position pos. For odd constants below 32 this never
  // yields more than three non-zero digits, i.e. at most two adders.
  function automatic int sau_csd_digit(input int c, input int pos);
    int n;
    int d;
    n = c;
    d = 0;
    for (int b = 0; b <= pos; b++) begin
      d = 0;
      if ((n % 2) != 0) begin
        d = ((n % 4) == 1) ? 1 : -1;
        n = n - d;
      end
      n = n / 2;
    end
    return d;
  endfunction

  localparam int SAU_OUT_W = sau_out_w(SAU_WIDTH, SAU_MULT_BITS);

  typedef struct packed {
    logic [NUM_MULT/2-1:0][SAU_OUT_W-1:0] odd;
    logic                                 neg;
    logic [SAU_TAG_W-1:0]                 tag;
  } sau_s1_t;

endpackage

// File: rtl/sau_pipe_if.sv
// ---------------------------------------------------------------------------
// sau_pipe_if
// Handshake bundle around the shift-add unit.
//   in_valid/in_ready : upstream handshake
//   in, in_neg, in_tag: signed sample, negate select, sideband tag
//   out_valid/out_ready: downstream handshake
//   out, out_tag       : NUM_MULT packed multiples and the returned tag
// Modports: master = the side that feeds samples and consumes results,
//           slave  = the shift-add unit itself.
// ---------------------------------------------------------------------------
interface sau_pipe_if
  import sau_pkg::*;
#(
  parameter int WIDTH     = 20,
  parameter int MULT_BITS = 4,
  parameter int TAG_W     = 8
);

  localparam int NMULT = 2 ** MULT_BITS;
  localparam int OUT_W = sau_out_w(WIDTH, MULT_BITS);

  logic                          in_valid;
  logic                          in_ready;
  logic signed [WIDTH-1:0]       in;
  logic                          in_neg;
  logic [TAG_W-1:0]              in_tag;
  logic                          out_valid;
  logic                          out_ready;
  logic [NMULT-1:0][OUT_W-1:0]   out;
  logic [TAG_W-1:0]              out_tag;

  modport master (
    output in_valid, in, in_neg, in_tag, out_ready,
    input  in_ready, out_valid, out, out_tag
  );

  modport slave (
    input  in_valid, in, in_neg, in_tag, out_ready,
    output in_ready, out_valid, out, out_tag
  );

endinterface

// File: rtl/sau_odd_gen.sv
// ---------------------------------------------------------------------------
// sau_odd_gen
// Combinational generator of the odd multiples (2j+1)*x, j = 0..NUM_MULT/2-1,
// using only shifts and adds/subtracts taken from the CSD recoding of each
// constant.
//   x_i   : sample already sign-extended to OUT_W
//   odd_o : odd multiples, odd_o[j] = (2j+1)*x_i
// ---------------------------------------------------------------------------
module sau_odd_gen
  import sau_pkg::*;
#(
  parameter int WIDTH     = 20,
  parameter int MULT_BITS = 4,
  localparam int OUT_W    = sau_out_w(WIDTH, MULT_BITS),
  localparam int HALF     = (2 ** MULT_BITS) / 2
) (
  input  logic signed [OUT_W-1:0]    x_i,
  output logic [HALF-1:0][OUT_W-1:0] odd_o
);

  for (genvar j = 0; j < HALF; j++) begin : g_odd
    localparam int C = 2 * j + 1;
    logic signed [OUT_W-1:0] acc;

    // Sum the signed-digit terms of C; zero digits fold away at elaboration,
    // leaving only the shifted copies that are really needed.
    always_comb begin
      acc = '0;
      for (int b = 0; b <= MULT_BITS; b++) begin
        if (sau_csd_digit(C, b) == 1) begin
          acc = acc + (x_i <<< b);
        end else if (sau_csd_digit(C, b) == -1) begin
          acc = acc - (x_i <<< b);
        end
      end
    end

    assign odd_o[j] = acc;
  end

endmodule

// File: rtl/sau_pipe.sv
// ---------------------------------------------------------------------------
// sau_pipe
// Two-stage pipelined shift-add unit producing all NUM_MULT multiples
// +/-(k+1)*in of one signed sample per cycle, with an optional per-sample
// negation and a sideband tag carried alongside.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, discards in-flight samples
//   bus : sau_pipe_if.slave (input and output valid/ready, data, tag)
// Stage 1 registers the odd multiples; stage 2 derives the even ones by
// shifting, applies the negation and registers the result vector.
// ---------------------------------------------------------------------------
module sau_pipe
  import sau_pkg::*;
#(
  parameter int WIDTH     = 20,
  parameter int MULT_BITS = 4,
  parameter int TAG_W     = 8
) (
  input  logic      clk,
  input  logic      rst,
  sau_pipe_if.slave bus
);

  localparam int NMULT = 2 ** MULT_BITS;
  localparam int HALF  = NMULT / 2;
  localparam int OUT_W = sau_out_w(WIDTH, MULT_BITS);

  typedef struct packed {
    logic [HALF-1:0][OUT_W-1:0] odd;
    logic                       neg;
    logic [TAG_W-1:0]           tag;
  } s1_rec_t;

  s1_rec_t                     s1_d, s1_q;
  logic                        v1_q, v2_q;
  logic [NMULT-1:0][OUT_W-1:0] out_d, out_q;
  logic [TAG_W-1:0]            tag2_q;
  logic                        en1, en2;
  logic signed [OUT_W-1:0]     x_ext;
  logic [HALF-1:0][OUT_W-1:0]  odd_w;

  // A stage may load when it is empty or when the stage after it is moving.
  assign en2 = !v2_q || bus.out_ready;
  assign en1 = !v1_q || en2;
  assign bus.in_ready = en1;

  assign x_ext = {{(OUT_W-WIDTH){bus.in[WIDTH-1]}}, bus.in};

  sau_odd_gen #(
    .WIDTH     (WIDTH),
    .MULT_BITS (MULT_BITS)
  ) u_odd_gen (
    .x_i   (x_ext),
    .odd_o (odd_w)
  );

  assign s1_d.odd = odd_w;
  assign s1_d.neg = bus.in_neg;
  assign s1_d.tag = bus.in_tag;

  // (k+1) = 2^SH * (2J+1): each even multiple is a shifted odd multiple.
  for (genvar k = 0; k < NMULT; k++) begin : g_even
    localparam int M  = k + 1;
    localparam int SH = sau_tz(M);
    localparam int J  = ((M >> SH) - 1) / 2;
    logic signed [OUT_W-1:0] mag;

    assign mag      = $signed(s1_q.odd[J]) <<< SH;
    assign out_d[k] = s1_q.neg ? -mag : mag;
  end

  // Pipeline registers; each stage holds its contents while stalled so the
  // presented result stays bit-stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      v1_q   <= 1'b0;
      out_q  <= '0;
      tag2_q <= '0;
      v2_q   <= 1'b0;
    end else begin
      if (en1) begin
        s1_q <= s1_d;
        v1_q <= bus.in_valid;
      end
      if (en2) begin
        out_q  <= out_d;
        tag2_q <= s1_q.tag;
        v2_q   <= v1_q;
      end
    end
  end

  // Valid is masked while reset is asserted so no result leaves in that cycle.
  assign bus.out_valid = v2_q && !rst;
  assign bus.out       = out_q;
  assign bus.out_tag   = tag2_q;

endmodule
